multicycle_main_fsm: RTL
========================

# multicycle_main_fsm

Main sequencing state machine for the multicycle ARM core. It walks each instruction through fetch, decode, execute, memory and writeback. It drives the shared-datapath mux selects and the architectural write strobes, and stalls on a memory ready handshake. The existing instruction decoder's Op/Funct fields feed it, and its RegW/MemW/Branch outputs go to the conditional-logic stage. The per-instruction ALU function and flag-write decode stay outside this block.

## Interface
- No parameters; widths are fixed by the ISA subset.
- CLK  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high; forces state FETCH.
- Op  in  2  instruction bits [27:26].
- Funct  in  6  instruction bits [25:20]; bit5 = I (immediate), bit0 = L (load) / S.
- MemReady  in  1  unified memory completes the current access this cycle.
- IRWrite  out  1  load instruction register.
- NextPC  out  1  PC write enable for sequential increment.
- RegW  out  1  register write request (pre-condition).
- MemW  out  1  memory write request (pre-condition).
- Branch  out  1  branch request (pre-condition).
- AdrSrc  out  1  0 = PC, 1 = ALUResult register.
- ALUSrcA  out  1  0 = RD1 register, 1 = PC.
- ALUSrcB  out  2  00 = RD2, 01 = ExtImm, 10 = constant 4.
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUOp  out  1  1 = ALU function from Funct, 0 = ADD.
- State  out  4  current state code, for debug.

## Operation
- States and codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9. Codes 10–15 are illegal and go to FETCH on the next edge.
- FETCH: AdrSrc 0, ALUSrcA 1, ALUSrcB 10, ALUOp 0, ResultSrc 10.
  - IRWrite and NextPC equal MemReady.
  - Go to DECODE when MemReady = 1; otherwise stay.
- DECODE: ALUSrcA 1, ALUSrcB 10, ALUOp 0, ResultSrc 10. Next state by Op:
  - Op 01 → MEMADR.
  - Op 00 with Funct[5] = 0 → EXECR.
  - Op 00 with Funct[5] = 1 → EXECI.
  - Op 10 → BRANCH.
  - Op 11 → FETCH (treated as a NOP; no strobes).
- MEMADR: ALUSrcA 0, ALUSrcB 01, ALUOp 0. Funct[0] = 1 → MEMRD; Funct[0] = 0 → MEMWR.
- MEMRD: AdrSrc 1, ResultSrc 00. Go to MEMWB when MemReady = 1; otherwise stay.
- MEMWB: ResultSrc 01, RegW 1 → FETCH.
- MEMWR: AdrSrc 1, ResultSrc 00, MemW 1.
  - MemW stays held every cycle of the wait.
  - Go to FETCH when MemReady = 1.
- EXECR: ALUSrcA 0, ALUSrcB 00, ALUOp 1 → ALUWB.
- EXECI: ALUSrcA 0, ALUSrcB 01, ALUOp 1 → ALUWB.
- ALUWB: ResultSrc 00, RegW 1 → FETCH.
- BRANCH: ALUSrcA 0, ALUSrcB 01, ALUOp 0, ResultSrc 10, Branch 1 → FETCH.
- Any output field not listed for a state is 0.
- Op and Funct are sampled only in DECODE and MEMADR. They are don't-care elsewhere, because the instruction register holds them stable.

## Timing
- Only State is registered. All outputs are combinational decodes of State, plus MemReady in FETCH.
- Base latencies with MemReady held at 1:
  - load 5 cycles
  - store 4 cycles
  - data-processing 4 cycles
  - branch 3 cycles
  - Op 11 2 cycles
- Each cycle with MemReady = 0 in FETCH, MEMRD or MEMWR adds one cycle to the instruction.
- MemReady is ignored in all other states.
- Reset, asserted at any time (including mid-instruction or mid-stall):
  - State goes to FETCH immediately, asynchronously.
  - While reset is high, IRWrite, NextPC, RegW, MemW and Branch are forced to 0.
  - Mux selects show the FETCH values.
- First fetch happens on the first rising edge after reset deasserts on which MemReady = 1.
- No strobe is ever high for more than one cycle, except MemW during a write stall.

## Structure
- Shared package `mc_pkg`:
  - state code constants
  - ALUSrcB encodings (SRCB_RD2, SRCB_IMM, SRCB_FOUR)
  - ResultSrc encodings (RES_ALUOUT, RES_DATA, RES_ALU)
  - Op encodings (OP_DP, OP_MEM, OP_BR)
- One sub-module, `mc_fsm_outdec`: a purely combinational State/MemReady → control-word decoder. The top level holds the state register and the next-state logic.

## Test plan
- Reset pulse mid-EXECR, MemReady = 1 → State = 0 within the same cycle; all strobes 0 while reset is high; IRWrite = 1 on the first cycle after release.
- Load: Op 01, Funct 011001, MemReady always 1 → State sequence 0,1,2,3,4,0; RegW = 1 only in cycle 5, with ResultSrc 01.
- Store with MemReady low for 2 cycles in MEMWR → MemW = 1 for 3 consecutive cycles; State = 0 on the cycle after MemReady rises.
- Data-processing: Op 00, Funct 101000 (immediate ADD) → EXECI with ALUSrcB 01, ALUOp 1; then ALUWB with RegW 1; 4 cycles total.
- Branch: Op 10 → State 0,1,9,0; Branch = 1 only in state 9, with ALUSrcA 0 and ALUSrcB 01. Op 11 → 0,1,0 with no strobes.
- Fetch stall with MemReady = 0 for 3 cycles → IRWrite and NextPC stay 0 and State stays 0; both strobes pulse for exactly 1 cycle when MemReady = 1.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle ARM main controller.
// State codes, mux-select encodings and the decoded control word.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    typedef struct packed {
        logic       irwrite;
        logic       nextpc;
        logic       regw;
        logic       memw;
        logic       branch;
        logic       adrsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic       aluop;
    } ctl_t;

endpackage

// File: rtl/multicycle_main_fsm_if.sv
// Decoder fields, memory handshake and control outputs of the main FSM.
// master = the controller, slave = the datapath side.
interface multicycle_main_fsm_if;

    logic [1:0] Op;
    logic [5:0] Funct;
    logic       MemReady;
    logic       IRWrite;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       ALUOp;
    logic [3:0] State;

    modport master (
        input  Op, Funct, MemReady,
        output IRWrite, NextPC, RegW, MemW, Branch,
        output AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
        output State
    );

    modport slave (
        output Op, Funct, MemReady,
        input  IRWrite, NextPC, RegW, MemW, Branch,
        input  AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
        input  State
    );

endinterface

// File: rtl/mc_fsm_outdec.sv
// Combinational control-word decode from the current state.
// Strobes are suppressed while hold (reset) is asserted.
module mc_fsm_outdec
    import mc_pkg::*;
(
    input  state_t state,
    input  logic   memready,
    input  logic   hold,
    output ctl_t   ctl
);

    // Per-state control word; unlisted fields stay 0
    always_comb begin
        ctl = '0;
        unique case (1'b1)
            (state == S_FETCH): begin
                ctl.irwrite   = memready;
                ctl.nextpc    = memready;
                ctl.alusrca   = 1'b1;
                ctl.alusrcb   = SRCB_FOUR;
                ctl.resultsrc = RES_ALU;
            end
            (state == S_DECODE): begin
                ctl.alusrca   = 1'b1;
                ctl.alusrcb   = SRCB_FOUR;
                ctl.resultsrc = RES_ALU;
            end
            (state == S_MEMADR): begin
                ctl.alusrcb = SRCB_IMM;
            end
            (state == S_MEMRD): begin
                ctl.adrsrc    = 1'b1;
                ctl.resultsrc = RES_ALUOUT;
            end
            (state == S_MEMWB): begin
                ctl.resultsrc = RES_DATA;
                ctl.regw      = 1'b1;
            end
            (state == S_MEMWR): begin
                ctl.adrsrc    = 1'b1;
                ctl.resultsrc = RES_ALUOUT;
                ctl.memw      = 1'b1;
            end
            (state == S_EXECR): begin
                ctl.alusrcb = SRCB_RD2;
                ctl.aluop   = 1'b1;
            end
            (state == S_EXECI): begin
                ctl.alusrcb = SRCB_IMM;
                ctl.aluop   = 1'b1;
            end
            (state == S_ALUWB): begin
                ctl.resultsrc = RES_ALUOUT;
                ctl.regw      = 1'b1;
            end
            (state == S_BRANCH): begin
                ctl.alusrcb   = SRCB_IMM;
                ctl.resultsrc = RES_ALU;
                ctl.branch    = 1'b1;
            end
            default: ctl = '0;
        endcase
        if (hold) begin
            ctl.irwrite = 1'b0;
            ctl.nextpc  = 1'b0;
            ctl.regw    = 1'b0;
            ctl.memw    = 1'b0;
            ctl.branch  = 1'b0;
        end
    end

endmodule

// File: rtl/multicycle_main_fsm.sv
// Main sequencing FSM of the multicycle ARM core.
// Holds the state register; outputs are decoded in mc_fsm_outdec.
module multicycle_main_fsm
    import mc_pkg::*;
(
    input  logic                   CLK,
    input  logic                   reset,
    multicycle_main_fsm_if.master  bus
);

    state_t state;
    ctl_t   ctl;

    logic unused_funct;
    assign unused_funct = ^bus.Funct[4:1];

    // State register and next-state selection; stalls on MemReady
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:
                    if (bus.MemReady) state <= S_DECODE;
                S_DECODE:
                    case (bus.Op)
                        OP_MEM:  state <= S_MEMADR;
                        OP_DP:   state <= bus.Funct[5] ? S_EXECI : S_EXECR;
                        OP_BR:   state <= S_BRANCH;
                        default: state <= S_FETCH;
                    endcase
                S_MEMADR:
                    state <= bus.Funct[0] ? S_MEMRD : S_MEMWR;
                S_MEMRD:
                    if (bus.MemReady) state <= S_MEMWB;
                S_MEMWR:
                    if (bus.MemReady) state <= S_FETCH;
                S_EXECR:  state <= S_ALUWB;
                S_EXECI:  state <= S_ALUWB;
                S_MEMWB:  state <= S_FETCH;
                S_ALUWB:  state <= S_FETCH;
                S_BRANCH: state <= S_FETCH;
                default:  state <= S_FETCH;
            endcase
        end
    end

    mc_fsm_outdec u_outdec (
        .state    (state),
        .memready (bus.MemReady),
        .hold     (reset),
        .ctl      (ctl)
    );

    assign bus.IRWrite   = ctl.irwrite;
    assign bus.NextPC    = ctl.nextpc;
    assign bus.RegW      = ctl.regw;
    assign bus.MemW      = ctl.memw;
    assign bus.Branch    = ctl.branch;
    assign bus.AdrSrc    = ctl.adrsrc;
    assign bus.ALUSrcA   = ctl.alusrca;
    assign bus.ALUSrcB   = ctl.alusrcb;
    assign bus.ResultSrc = ctl.resultsrc;
    assign bus.ALUOp     = ctl.aluop;
    assign bus.State     = state;

endmodule
